// File: rtl/cursor_position_tracker.sv
// Decodes a 3-byte PS/2 mouse packet stream into button levels and pending motion,
// then applies the pending motion to a clamped sprite position once per frame.
module cursor_position_tracker #(
    parameter int unsigned SCREEN_W       = 640,
    parameter int unsigned SCREEN_H       = 480,
    parameter int unsigned SPRITE_W       = 64,
    parameter int unsigned SPRITE_H       = 64,
    parameter int unsigned INIT_X         = 288,
    parameter int unsigned INIT_Y         = 208,
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter int unsigned ACC_W          = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       frame_start,
    output logic [9:0] sprite_x,
    output logic [8:0] sprite_y,
    output logic       btn_left,
    output logic       btn_right,
    output logic       click,
    output logic       pkt_done,
    output logic       sync_err
);

    localparam int unsigned MAX_X = SCREEN_W - SPRITE_W;
    localparam int unsigned MAX_Y = SCREEN_H - SPRITE_H;
    localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);
    // Sum width covers both the 10-bit position and the signed accumulator with headroom.
    localparam int unsigned PW    = ((ACC_W > 10) ? ACC_W : 10) + 2;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;
    localparam logic signed [PW-1:0]    SAT_HI  = PW'(ACC_MAX);
    localparam logic signed [PW-1:0]    SAT_LO  = PW'(ACC_MIN);
    localparam logic signed [PW-1:0]    MAX_X_S = PW'(MAX_X);
    localparam logic signed [PW-1:0]    MAX_Y_S = PW'(MAX_Y);
    localparam logic [TW-1:0]           TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        B0 = 2'd0,
        B1 = 2'd1,
        B2 = 2'd2
    } state_t;

    typedef struct packed {
        logic oy;
        logic ox;
        logic sy;
        logic sx;
        logic r;
        logic l;
    } hdr_t;

    state_t                   state;
    hdr_t                     hdr;
    logic [7:0]               dx_lo;
    logic [TW-1:0]            tcnt;
    logic signed [ACC_W-1:0]  acc_x;
    logic signed [ACC_W-1:0]  acc_y;

    logic                     pkt_fire;
    logic                     timeout;
    logic signed [PW-1:0]     dx_ext;
    logic signed [PW-1:0]     dy_ext;
    logic signed [PW-1:0]     base_x;
    logic signed [PW-1:0]     base_y;
    logic signed [PW-1:0]     sum_x;
    logic signed [PW-1:0]     sum_y;
    logic signed [PW-1:0]     nx;
    logic signed [PW-1:0]     ny;
    logic signed [ACC_W-1:0]  acc_x_nxt;
    logic signed [ACC_W-1:0]  acc_y_nxt;
    logic [9:0]               nx_clamped;
    logic [8:0]               ny_clamped;

    function automatic logic signed [ACC_W-1:0] sat(input logic signed [PW-1:0] v);
        if (v > SAT_HI) begin
            return ACC_MAX;
        end else if (v < SAT_LO) begin
            return ACC_MIN;
        end else begin
            return ACC_W'(v);
        end
    endfunction

    // Packet delta accumulation and per-frame position update.
    always_comb begin
        pkt_fire   = rx_valid && (state == B2);
        timeout    = (state != B0) && !rx_valid && (tcnt == TMO_LAST);

        dx_ext     = PW'($signed({hdr.sx, dx_lo}));
        dy_ext     = PW'($signed({hdr.sy, rx_data}));

        // A coincident frame consumes the old totals, so the new packet starts from zero.
        base_x     = frame_start ? '0 : PW'(acc_x);
        base_y     = frame_start ? '0 : PW'(acc_y);
        sum_x      = hdr.ox ? base_x : base_x + dx_ext;
        sum_y      = hdr.oy ? base_y : base_y - dy_ext;

        acc_x_nxt  = acc_x;
        acc_y_nxt  = acc_y;
        if (pkt_fire) begin
            acc_x_nxt = sat(sum_x);
            acc_y_nxt = sat(sum_y);
        end else if (frame_start) begin
            acc_x_nxt = '0;
            acc_y_nxt = '0;
        end

        nx         = PW'($signed({1'b0, sprite_x})) + PW'(acc_x);
        ny         = PW'($signed({1'b0, sprite_y})) + PW'(acc_y);

        nx_clamped = nx[9:0];
        if (nx[PW-1]) begin
            nx_clamped = '0;
        end else if (nx > MAX_X_S) begin
            nx_clamped = 10'(MAX_X);
        end

        ny_clamped = ny[8:0];
        if (ny[PW-1]) begin
            ny_clamped = '0;
        end else if (ny > MAX_Y_S) begin
            ny_clamped = 9'(MAX_Y);
        end
    end

    // Packet framing FSM with inter-byte timeout, plus registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= B0;
            hdr       <= '0;
            dx_lo     <= '0;
            tcnt      <= '0;
            acc_x     <= '0;
            acc_y     <= '0;
            sprite_x  <= 10'(INIT_X);
            sprite_y  <= 9'(INIT_Y);
            btn_left  <= 1'b0;
            btn_right <= 1'b0;
            click     <= 1'b0;
            pkt_done  <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            click    <= 1'b0;
            pkt_done <= 1'b0;
            sync_err <= 1'b0;
            acc_x    <= acc_x_nxt;
            acc_y    <= acc_y_nxt;

            if (frame_start) begin
                sprite_x <= nx_clamped;
                sprite_y <= ny_clamped;
            end

            unique case (state)
                B0: begin
                    tcnt <= '0;
                    if (rx_valid) begin
                        if (rx_data[3]) begin
                            hdr   <= '{oy: rx_data[7], ox: rx_data[6], sy: rx_data[5],
                                       sx: rx_data[4], r: rx_data[1], l: rx_data[0]};
                            state <= B1;
                        end else begin
                            sync_err <= 1'b1;
                        end
                    end
                end
                B1: begin
                    if (rx_valid) begin
                        dx_lo <= rx_data;
                        tcnt  <= '0;
                        state <= B2;
                    end else if (timeout) begin
                        sync_err <= 1'b1;
                        tcnt     <= '0;
                        state    <= B0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                B2: begin
                    if (rx_valid) begin
                        btn_left  <= hdr.l;
                        btn_right <= hdr.r;
                        click     <= hdr.l && !btn_left;
                        pkt_done  <= 1'b1;
                        tcnt      <= '0;
                        state     <= B0;
                    end else if (timeout) begin
                        sync_err <= 1'b1;
                        tcnt     <= '0;
                        state    <= B0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: begin
                    tcnt  <= '0;
                    state <= B0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cursor_position_tracker.sv
// Bench for cursor_position_tracker: fixed vectors, directed corner sequences and
// random traffic compared every cycle against an integer reference model.
module tb_cursor_position_tracker;

    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] sprite_x;
    logic [8:0] sprite_y;
    logic       btn_left;
    logic       btn_right;
    logic       click;
    logic       pkt_done;
    logic       sync_err;

    cursor_position_tracker #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_start(frame_start),
        .sprite_x   (sprite_x),
        .sprite_y   (sprite_y),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .click      (click),
        .pkt_done   (pkt_done),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int         m_x, m_y, m_ax, m_ay, m_idle;
    bit         m_bl, m_br, m_click, m_pd, m_se;
    logic [7:0] pkt[$];

    typedef struct {
        bit       rv;
        bit [7:0] rd;
        bit       fs;
        int       ex;
        int       ey;
        bit       epd;
        bit       ese;
        bit       ebl;
        bit       eck;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic void model_reset();
        m_x = 288; m_y = 208; m_ax = 0; m_ay = 0; m_idle = 0;
        m_bl = 0; m_br = 0; m_click = 0; m_pd = 0; m_se = 0;
        pkt.delete();
    endfunction

    function automatic void model_update(input bit rv, input bit [7:0] rd, input bit fs);
        bit [7:0] h;
        int dx, dy;
        m_pd = 0; m_se = 0; m_click = 0;
        if (fs) begin
            m_x  = clampi(m_x + m_ax, 0, 640 - 64);
            m_y  = clampi(m_y + m_ay, 0, 480 - 64);
            m_ax = 0;
            m_ay = 0;
        end
        if (rv) begin
            m_idle = 0;
            if (pkt.size() == 0 && !rd[3]) begin
                m_se = 1;
            end else begin
                pkt.push_back(rd);
                if (pkt.size() == 3) begin
                    h  = pkt[0];
                    dx = int'(pkt[1]) - (h[4] ? 256 : 0);
                    dy = int'(pkt[2]) - (h[5] ? 256 : 0);
                    if (!h[6]) m_ax = clampi(m_ax + dx, -2047, 2047);
                    if (!h[7]) m_ay = clampi(m_ay - dy, -2047, 2047);
                    m_click = h[0] && !m_bl;
                    m_bl    = h[0];
                    m_br    = h[1];
                    m_pd    = 1;
                    pkt.delete();
                end
            end
        end else if (pkt.size() != 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_se   = 1;
                m_idle = 0;
                pkt.delete();
            end
        end
    endfunction

    task automatic compare_model();
        check("sprite_x",  int'(sprite_x),  m_x);
        check("sprite_y",  int'(sprite_y),  m_y);
        check("btn_left",  int'(btn_left),  int'(m_bl));
        check("btn_right", int'(btn_right), int'(m_br));
        check("click",     int'(click),     int'(m_click));
        check("pkt_done",  int'(pkt_done),  int'(m_pd));
        check("sync_err",  int'(sync_err),  int'(m_se));
    endtask

    // One clock: drive at negedge, sample 1 time unit after the rising edge.
    task automatic step(input bit rv, input bit [7:0] rd, input bit fs);
        @(negedge clk);
        rx_valid    = rv;
        rx_data     = rd;
        frame_start = fs;
        @(posedge clk);
        #1;
        model_update(rv, rd, fs);
        compare_model();
        rx_valid    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_pkt(input bit [7:0] b0, input bit [7:0] b1, input bit [7:0] b2);
        step(1'b1, b0, 1'b0);
        step(1'b1, b1, 1'b0);
        step(1'b1, b2, 1'b0);
    endtask

    function automatic void add_vec(input bit rv, input bit [7:0] rd, input bit fs,
                                    input int ex, input int ey,
                                    input bit epd, input bit ese, input bit ebl, input bit eck);
        vec_t v;
        v.rv = rv; v.rd = rd; v.fs = fs; v.ex = ex; v.ey = ey;
        v.epd = epd; v.ese = ese; v.ebl = ebl; v.eck = eck;
        vecs.push_back(v);
    endfunction

    initial begin
        int x0;
        int se_cnt;
        int burst;
        bit rv;
        bit fs;
        bit [7:0] rd;

        // Packet 08,0A,05 then frame; resync byte; button press; y clamp; x overflow discard.
        add_vec(1, 8'h08, 0, 288, 208, 0, 0, 0, 0);
        add_vec(1, 8'h0A, 0, 288, 208, 0, 0, 0, 0);
        add_vec(1, 8'h05, 0, 288, 208, 1, 0, 0, 0);
        add_vec(0, 8'h00, 1, 298, 203, 0, 0, 0, 0);
        add_vec(0, 8'h00, 0, 298, 203, 0, 0, 0, 0);
        add_vec(1, 8'h02, 0, 298, 203, 0, 1, 0, 0);
        add_vec(1, 8'h09, 0, 298, 203, 0, 0, 0, 0);
        add_vec(1, 8'h00, 0, 298, 203, 0, 0, 0, 0);
        add_vec(1, 8'h00, 0, 298, 203, 1, 0, 1, 1);
        add_vec(0, 8'h00, 0, 298, 203, 0, 0, 1, 0);
        add_vec(1, 8'h09, 0, 298, 203, 0, 0, 1, 0);
        add_vec(1, 8'h00, 0, 298, 203, 0, 0, 1, 0);
        add_vec(1, 8'h00, 0, 298, 203, 1, 0, 1, 0);
        add_vec(0, 8'h00, 1, 298, 203, 0, 0, 1, 0);
        add_vec(1, 8'h28, 0, 298, 203, 0, 0, 1, 0);
        add_vec(1, 8'h00, 0, 298, 203, 0, 0, 1, 0);
        add_vec(1, 8'h03, 0, 298, 203, 1, 0, 0, 0);
        add_vec(0, 8'h00, 1, 298, 416, 0, 0, 0, 0);
        add_vec(1, 8'h48, 0, 298, 416, 0, 0, 0, 0);
        add_vec(1, 8'h50, 0, 298, 416, 0, 0, 0, 0);
        add_vec(1, 8'h00, 0, 298, 416, 1, 0, 0, 0);
        add_vec(0, 8'h00, 1, 298, 416, 0, 0, 0, 0);

        model_reset();
        repeat (3) @(negedge clk);
        check("reset_x",     int'(sprite_x), 288);
        check("reset_y",     int'(sprite_y), 208);
        check("reset_pulse", int'({click, pkt_done, sync_err, btn_left, btn_right}), 0);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].rv, vecs[i].rd, vecs[i].fs);
            check("vec_x",        int'(sprite_x), vecs[i].ex);
            check("vec_y",        int'(sprite_y), vecs[i].ey);
            check("vec_pkt_done", int'(pkt_done), int'(vecs[i].epd));
            check("vec_sync_err", int'(sync_err), int'(vecs[i].ese));
            check("vec_btn_left", int'(btn_left), int'(vecs[i].ebl));
            check("vec_click",    int'(click),    int'(vecs[i].eck));
        end

        // Left clamp, then right clamp.
        for (int i = 0; i < 40; i++) send_pkt(8'h18, 8'hF6, 8'h00);
        step(1'b0, 8'h00, 1'b1);
        check("clamp_left", int'(sprite_x), 0);
        for (int i = 0; i < 10; i++) send_pkt(8'h08, 8'h7F, 8'h00);
        step(1'b0, 8'h00, 1'b1);
        check("clamp_right", int'(sprite_x), 576);

        // Accumulator saturation in both directions (a wrap would land on the opposite edge).
        for (int i = 0; i < 20; i++) send_pkt(8'h18, 8'h81, 8'h00);
        step(1'b0, 8'h00, 1'b1);
        check("sat_neg", int'(sprite_x), 0);
        for (int i = 0; i < 20; i++) send_pkt(8'h08, 8'h7F, 8'h00);
        step(1'b0, 8'h00, 1'b1);
        check("sat_pos", int'(sprite_x), 576);
        send_pkt(8'h18, 8'hE2, 8'h00);
        step(1'b0, 8'h00, 1'b1);
        check("move_back", int'(sprite_x), 546);

        // Packet completion coincident with frame_start.
        x0 = m_x;
        send_pkt(8'h08, 8'h02, 8'h00);
        step(1'b1, 8'h08, 1'b0);
        step(1'b1, 8'h03, 1'b0);
        step(1'b1, 8'h00, 1'b1);
        check("coinc_frame1", int'(sprite_x), x0 + 2);
        check("coinc_pkt",    int'(pkt_done), 1);
        step(1'b0, 8'h00, 1'b1);
        check("coinc_frame2", int'(sprite_x), x0 + 5);

        // Inter-byte timeout discards the partial packet.
        x0 = m_x;
        step(1'b1, 8'h08, 1'b0);
        step(1'b1, 8'h05, 1'b0);
        se_cnt = 0;
        for (int i = 0; i < TMO + 3; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (sync_err) se_cnt++;
            if (i == TMO - 1) check("timeout_edge", int'(sync_err), 1);
        end
        check("timeout_count", se_cnt, 1);
        send_pkt(8'h08, 8'h01, 8'h00);
        check("after_tmo_pkt", int'(pkt_done), 1);
        step(1'b0, 8'h00, 1'b1);
        check("after_tmo_x", int'(sprite_x), x0 + 1);

        // A byte arriving in the expiry cycle wins over the timeout.
        x0 = m_x;
        step(1'b1, 8'h08, 1'b0);
        step(1'b1, 8'h01, 1'b0);
        for (int i = 0; i < TMO - 1; i++) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        check("byte_wins_se", int'(sync_err), 0);
        check("byte_wins_pd", int'(pkt_done), 1);
        step(1'b0, 8'h00, 1'b1);
        check("byte_wins_x", int'(sprite_x), x0 + 1);

        // Asynchronous reset in the middle of a packet with motion pending.
        send_pkt(8'h09, 8'h7F, 8'h00);
        step(1'b1, 8'h08, 1'b0);
        step(1'b1, 8'h05, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_x",   int'(sprite_x), 288);
        check("midrst_y",   int'(sprite_y), 208);
        check("midrst_btn", int'(btn_left), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b1);
        check("midrst_frame", int'(sprite_x), 288);
        step(1'b1, 8'h00, 1'b0);
        check("midrst_resync", int'(sync_err), 1);

        // Random traffic against the reference model.
        burst = 0;
        for (int i = 0; i < 5000; i++) begin
            if (burst > 0) begin
                rv = 1'b0;
                burst--;
            end else begin
                rv = ($urandom % 3) == 0;
                if (($urandom % 250) == 0) burst = TMO - 2 + int'($urandom % 4);
            end
            rd = 8'($urandom);
            if (pkt.size() == 0 && ($urandom % 4) != 0) rd[3] = 1'b1;
            fs = ($urandom % 40) == 0;
            step(rv, rd, fs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
